udp_pat_gen_mw: RTL and testbench

Multi-byte-lane, parametrised UDP/IPv4/Ethernet test-frame generator. Streams complete frames (MAC header, IPv4 header, UDP header, payload) on an AXI4-Stream master of DATA_BYTES lanes with tkeep, and feeds the TSE MAC TX path at line rate on wide datapaths. Adds the following over the byte-wide generator:
- selectable payload modes;
- abort-after-frame stop;
- a frame counter;
- guaranteed AXI stability under backpressure.

---
 rtl/udp_pat_gen_mw.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_udp_pat_gen_mw.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_pat_gen_mw.sv
// udp_pat_gen_mw: multi-lane UDP/IPv4/Ethernet test-frame generator.
// Emits complete frames (MAC, IPv4, UDP headers and payload) on an AXI4-Stream
// master DATA_BYTES lanes wide. Lane 0 (tdata[7:0]) is first on the wire.
// Ports:
//   clk, rstn                    clock, asynchronous active-low reset
//   pat_gen_en                   rising edge starts a run (ignored while busy)
//   pat_gen_stop                 level; finish the current frame, then idle
//   pat_gen_num / pat_gen_ipg    frames per run (0 = infinite) / idle gap cycles
//   pat_mode, pat_seed           payload pattern select and seed byte
//   dst_mac..dst_port, udp_dlen  frame header fields and payload length
//   tdata/tkeep/tvalid/tlast     stream master; tready from the sink
//   busy, frame_cnt              run active; frames accepted since reset
module udp_pat_gen_mw #(
  parameter int DATA_BYTES = 4,
  parameter int CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    pat_gen_en,
  input  logic                    pat_gen_stop,
  input  logic [CNT_W-1:0]        pat_gen_num,
  input  logic [CNT_W-1:0]        pat_gen_ipg,
  input  logic [1:0]              pat_mode,
  input  logic [7:0]              pat_seed,
  input  logic [47:0]             dst_mac,
  input  logic [47:0]             src_mac,
  input  logic [31:0]             src_ip,
  input  logic [31:0]             dst_ip,
  input  logic [15:0]             src_port,
  input  logic [15:0]             dst_port,
  input  logic [15:0]             udp_dlen,
  output logic [8*DATA_BYTES-1:0] tdata,
  output logic [DATA_BYTES-1:0]   tkeep,
  output logic                    tvalid,
  output logic                    tlast,
  input  logic                    tready,
  output logic                    busy,
  output logic [31:0]             frame_cnt
);
  localparam int DW = 8 * DATA_BYTES;

  typedef enum logic [1:0] {IDLE, CALC, GEN, IPG} state_t;
  state_t state_reg, state_next;

  logic [1:0]       en_sync_reg;
  logic             en_prev_reg;
  logic [CNT_W-1:0] sh_ipg_reg, remaining_reg, ipg_cnt_reg;
  logic [1:0]       sh_mode_reg;
  logic [7:0]       sh_seed_reg, frame_idx_reg;
  logic [47:0]      sh_dst_mac_reg, sh_src_mac_reg;
  logic [31:0]      sh_src_ip_reg, sh_dst_ip_reg, frame_cnt_reg;
  logic [15:0]      sh_src_port_reg, sh_dst_port_reg, sh_dlen_reg;
  logic             run_finite_reg, stop_seen_reg;
  logic [15:0]      ip_id_reg, calc_idx_reg, base_reg;
  logic [15:0]      ip_sum_reg, udp_sum_reg, ip_csum_reg, udp_csum_reg;
  logic [DW-1:0]    tdata_reg;
  logic [DATA_BYTES-1:0] tkeep_reg;
  logic             tvalid_reg, tlast_reg;

  logic start_pulse, accept, latch_cfg, run_start, calc_fold;
  logic [15:0] ip_len, udp_len, frame_len, calc_last, beat_base;
  logic [15:0] ip_word, udp_word, pay_word, pay_k;
  logic [DW-1:0] lane_data;
  logic [DATA_BYTES-1:0] lane_keep;
  logic beat_last;

  assign start_pulse = en_sync_reg[1] & ~en_prev_reg;
  assign accept      = tvalid_reg & tready;
  assign ip_len      = sh_dlen_reg + 16'd28;
  assign udp_len     = sh_dlen_reg + 16'd8;
  assign frame_len   = sh_dlen_reg + 16'd42;
  // 9 header words, then one word per payload byte pair; the cycle after is the fold.
  assign calc_last   = ((sh_dlen_reg + 16'd1) >> 1) + 16'd9;

  function automatic logic [15:0] csum_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

  // Payload byte k; mode 3 falls through to the mode 0 behaviour.
  function automatic logic [7:0] pay_byte(input logic [15:0] k);
    logic [7:0] v;
    v = sh_seed_reg;
    if (sh_mode_reg != 2'd1) v = v + k[7:0];
    if (sh_mode_reg == 2'd2) v = v + frame_idx_reg;
    return v;
  endfunction

  function automatic logic [7:0] hdr_byte(input int n);
    logic [7:0] b;
    b = 8'h00;
    if (n < 6)       b = sh_dst_mac_reg[8*(5-n) +: 8];
    else if (n < 12) b = sh_src_mac_reg[8*(11-n) +: 8];
    else if (n >= 26 && n < 30) b = sh_src_ip_reg[8*(29-n) +: 8];
    else if (n >= 30 && n < 34) b = sh_dst_ip_reg[8*(33-n) +: 8];
    else begin
      case (n)
        12: b = 8'h08;
        14: b = 8'h45;
        16: b = ip_len[15:8];
        17: b = ip_len[7:0];
        18: b = ip_id_reg[15:8];
        19: b = ip_id_reg[7:0];
        22: b = 8'h40;
        23: b = 8'h11;
        24: b = ip_csum_reg[15:8];
        25: b = ip_csum_reg[7:0];
        34: b = sh_src_port_reg[15:8];
        35: b = sh_src_port_reg[7:0];
        36: b = sh_dst_port_reg[15:8];
        37: b = sh_dst_port_reg[7:0];
        38: b = udp_len[15:8];
        39: b = udp_len[7:0];
        40: b = udp_csum_reg[15:8];
        41: b = udp_csum_reg[7:0];
        default: b = 8'h00;
      endcase
    end
    return b;
  endfunction

  function automatic logic [7:0] frame_byte(input logic [15:0] n);
    if (n < 16'd42) return hdr_byte(int'(n));
    return pay_byte(n - 16'd42);
  endfunction

  // Beat 0 is built during the fold cycle; its bytes (< 8) never touch the checksums.
  assign beat_base = (state_reg == CALC) ? 16'd0 : base_reg;
  assign beat_last = (beat_base + 16'(DATA_BYTES)) >= frame_len;

  genvar gi;
  generate
    for (gi = 0; gi < DATA_BYTES; gi++) begin : g_lane
      logic [15:0] lane_n;
      assign lane_n                = beat_base + 16'(gi);
      assign lane_keep[gi]         = lane_n < frame_len;
      assign lane_data[8*gi +: 8]  = lane_keep[gi] ? frame_byte(lane_n) : 8'h00;
    end
  endgenerate

  // Checksum word sources for the current CALC step (IPv4 and UDP run in parallel).
  always_comb begin
    pay_k    = (calc_idx_reg - 16'd9) << 1;
    pay_word = {pay_byte(pay_k), ((pay_k + 16'd1) < sh_dlen_reg) ? pay_byte(pay_k + 16'd1) : 8'h00};
    ip_word  = 16'h0000;
    udp_word = pay_word;
    case (calc_idx_reg)
      16'd0: begin ip_word = 16'h4500;              udp_word = sh_src_ip_reg[31:16]; end
      16'd1: begin ip_word = ip_len;                udp_word = sh_src_ip_reg[15:0];  end
      16'd2: begin ip_word = ip_id_reg;             udp_word = sh_dst_ip_reg[31:16]; end
      16'd3: begin ip_word = 16'h0000;              udp_word = sh_dst_ip_reg[15:0];  end
      16'd4: begin ip_word = 16'h4011;              udp_word = 16'h0011;             end
      16'd5: begin ip_word = sh_src_ip_reg[31:16];  udp_word = udp_len;              end
      16'd6: begin ip_word = sh_src_ip_reg[15:0];   udp_word = sh_src_port_reg;      end
      16'd7: begin ip_word = sh_dst_ip_reg[31:16];  udp_word = sh_dst_port_reg;      end
      16'd8: begin ip_word = sh_dst_ip_reg[15:0];   udp_word = udp_len;              end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    latch_cfg  = 1'b0;
    run_start  = 1'b0;
    calc_fold  = 1'b0;
    case (state_reg)
      IDLE: if (start_pulse && !pat_gen_stop) begin
        state_next = CALC;
        latch_cfg  = 1'b1;
        run_start  = 1'b1;
      end
      CALC: if (pat_gen_stop) state_next = IDLE;
            else if (calc_idx_reg == calc_last) begin
              state_next = GEN;
              calc_fold  = 1'b1;
            end
      GEN:  if (accept && tlast_reg) state_next = IPG;
      IPG:  if (stop_seen_reg || pat_gen_stop || (run_finite_reg && remaining_reg == '0))
              state_next = IDLE;
            else if (ipg_cnt_reg >= sh_ipg_reg) begin
              state_next = CALC;
              latch_cfg  = 1'b1;
            end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      en_sync_reg <= '0;  en_prev_reg <= 1'b0;
      sh_ipg_reg <= '0;   remaining_reg <= '0;  ipg_cnt_reg <= '0;
      sh_mode_reg <= '0;  sh_seed_reg <= '0;    frame_idx_reg <= '0;
      sh_dst_mac_reg <= '0; sh_src_mac_reg <= '0;
      sh_src_ip_reg <= '0;  sh_dst_ip_reg <= '0;  frame_cnt_reg <= '0;
      sh_src_port_reg <= '0; sh_dst_port_reg <= '0; sh_dlen_reg <= '0;
      run_finite_reg <= 1'b0; stop_seen_reg <= 1'b0;
      ip_id_reg <= '0;  calc_idx_reg <= '0;  base_reg <= '0;
      ip_sum_reg <= '0; udp_sum_reg <= '0;   ip_csum_reg <= '0; udp_csum_reg <= '0;
      tdata_reg <= '0;  tkeep_reg <= '0;     tvalid_reg <= 1'b0; tlast_reg <= 1'b0;
    end else begin
      en_sync_reg <= {en_sync_reg[0], pat_gen_en};
      en_prev_reg <= en_sync_reg[1];

      if (latch_cfg) begin
        sh_ipg_reg      <= pat_gen_ipg;
        sh_mode_reg     <= pat_mode;
        sh_seed_reg     <= pat_seed;
        sh_dst_mac_reg  <= dst_mac;
        sh_src_mac_reg  <= src_mac;
        sh_src_ip_reg   <= src_ip;
        sh_dst_ip_reg   <= dst_ip;
        sh_src_port_reg <= src_port;
        sh_dst_port_reg <= dst_port;
        sh_dlen_reg     <= udp_dlen;
        calc_idx_reg    <= '0;
        ip_sum_reg      <= '0;
        udp_sum_reg     <= '0;
      end
      if (run_start) begin
        remaining_reg  <= pat_gen_num;
        run_finite_reg <= (pat_gen_num != '0);
        stop_seen_reg  <= 1'b0;
        frame_idx_reg  <= '0;
      end

      if (state_reg == CALC && !calc_fold) begin
        calc_idx_reg <= calc_idx_reg + 16'd1;
        ip_sum_reg   <= csum_add(ip_sum_reg, ip_word);
        udp_sum_reg  <= csum_add(udp_sum_reg, udp_word);
      end
      if (calc_fold) begin
        ip_csum_reg  <= ~ip_sum_reg;
        // An all-zero UDP checksum means "none", so a true zero goes out as 0xFFFF.
        udp_csum_reg <= (udp_sum_reg == 16'hFFFF) ? 16'hFFFF : ~udp_sum_reg;
        tdata_reg    <= lane_data;
        tkeep_reg    <= lane_keep;
        tlast_reg    <= beat_last;
        tvalid_reg   <= 1'b1;
        base_reg     <= 16'(DATA_BYTES);
      end

      if (state_reg == GEN) begin
        if (pat_gen_stop) stop_seen_reg <= 1'b1;
        // Outputs only move on acceptance, so they are stable under backpressure.
        if (accept) begin
          if (tlast_reg) begin
            tvalid_reg    <= 1'b0;
            tdata_reg     <= '0;
            tkeep_reg     <= '0;
            tlast_reg     <= 1'b0;
            ip_id_reg     <= ip_id_reg + 16'd1;
            frame_cnt_reg <= frame_cnt_reg + 32'd1;
            frame_idx_reg <= frame_idx_reg + 8'd1;
            ipg_cnt_reg   <= '0;
            if (remaining_reg != '0) remaining_reg <= remaining_reg - 1'b1;
          end else begin
            tdata_reg <= lane_data;
            tkeep_reg <= lane_keep;
            tlast_reg <= beat_last;
            base_reg  <= base_reg + 16'(DATA_BYTES);
          end
        end
      end

      if (state_reg == IPG) ipg_cnt_reg <= ipg_cnt_reg + 1'b1;
    end
  end

  assign tdata     = tdata_reg;
  assign tkeep     = tkeep_reg;
  assign tvalid    = tvalid_reg;
  assign tlast     = tlast_reg;
  assign busy      = (state_reg != IDLE);
  assign frame_cnt = frame_cnt_reg;
endmodule

// File: tb/tb_udp_pat_gen_mw.sv
// Testbench for udp_pat_gen_mw: a byte-level frame model builds every expected
// frame from the field rules; a negedge monitor compares each accepted beat and
// checks stability under stalls, tvalid hold within a frame and the IPG gap.
module tb_udp_pat_gen_mw;
  localparam int DB = 4;
  localparam int CW = 16;

  logic clk, rstn, pat_gen_en, pat_gen_stop, tready;
  logic [CW-1:0] pat_gen_num, pat_gen_ipg;
  logic [1:0] pat_mode;
  logic [7:0] pat_seed;
  logic [47:0] dst_mac, src_mac;
  logic [31:0] src_ip, dst_ip;
  logic [15:0] src_port, dst_port, udp_dlen;
  logic [8*DB-1:0] tdata;
  logic [DB-1:0] tkeep;
  logic tvalid, tlast, busy;
  logic [31:0] frame_cnt;

  udp_pat_gen_mw #(.DATA_BYTES(DB), .CNT_W(CW)) dut (
    .clk(clk), .rstn(rstn), .pat_gen_en(pat_gen_en), .pat_gen_stop(pat_gen_stop),
    .pat_gen_num(pat_gen_num), .pat_gen_ipg(pat_gen_ipg), .pat_mode(pat_mode),
    .pat_seed(pat_seed), .dst_mac(dst_mac), .src_mac(src_mac), .src_ip(src_ip),
    .dst_ip(dst_ip), .src_port(src_port), .dst_port(dst_port), .udp_dlen(udp_dlen),
    .tdata(tdata), .tkeep(tkeep), .tvalid(tvalid), .tlast(tlast), .tready(tready),
    .busy(busy), .frame_cnt(frame_cnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  logic [7:0] exp_bytes[$];
  int exp_len[$];
  logic [7:0] frm [0:1599];
  int frm_len, model_ip_id, model_frame_cnt, frames_seen, cur_ipg;
  int cfg_dlen, cfg_mode, cfg_seed;
  bit rand_ready;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got=%0h want=%0h", nm, act, req);
    end
  endtask

  // Byte-level model of one frame, straight from the field layout.
  task automatic build_frame(input int fidx);
    int L, il, ul, s, c, v;
    L = cfg_dlen + 42; il = cfg_dlen + 28; ul = cfg_dlen + 8;
    for (int i = 0; i < L; i++) frm[i] = 8'h00;
    for (int i = 0; i < 6; i++) begin
      frm[i] = dst_mac[8*(5-i) +: 8];
      frm[6+i] = src_mac[8*(5-i) +: 8];
    end
    frm[12] = 8'h08; frm[14] = 8'h45;
    frm[16] = 8'(il >> 8); frm[17] = 8'(il);
    frm[18] = 8'(model_ip_id >> 8); frm[19] = 8'(model_ip_id);
    frm[22] = 8'h40; frm[23] = 8'h11;
    for (int i = 0; i < 4; i++) begin
      frm[26+i] = src_ip[8*(3-i) +: 8];
      frm[30+i] = dst_ip[8*(3-i) +: 8];
    end
    frm[34] = src_port[15:8]; frm[35] = src_port[7:0];
    frm[36] = dst_port[15:8]; frm[37] = dst_port[7:0];
    frm[38] = 8'(ul >> 8); frm[39] = 8'(ul);
    for (int k = 0; k < cfg_dlen; k++) begin
      v = cfg_seed + ((cfg_mode == 1) ? 0 : k) + ((cfg_mode == 2) ? fidx : 0);
      frm[42+k] = 8'(v);
    end
    s = 0;
    for (int i = 14; i < 34; i += 2) s += (int'(frm[i]) << 8) + int'(frm[i+1]);
    while (s > 16'hFFFF) s = (s & 16'hFFFF) + (s >> 16);
    c = ~s & 16'hFFFF;
    frm[24] = 8'(c >> 8); frm[25] = 8'(c);
    s = int'(src_ip[31:16]) + int'(src_ip[15:0]) + int'(dst_ip[31:16]) + int'(dst_ip[15:0]) + 17 + ul;
    for (int i = 34; i < L; i += 2) s += (int'(frm[i]) << 8) + ((i + 1 < L) ? int'(frm[i+1]) : 0);
    while (s > 16'hFFFF) s = (s & 16'hFFFF) + (s >> 16);
    c = ~s & 16'hFFFF;
    if (c == 0) c = 16'hFFFF;
    frm[40] = 8'(c >> 8); frm[41] = 8'(c);
    for (int i = 0; i < L; i++) exp_bytes.push_back(frm[i]);
    exp_len.push_back(L);
    frm_len = L;
    model_ip_id = (model_ip_id + 1) & 16'hFFFF;
  endtask

  // Monitor state
  int pos = 0, beats = 0, last_beats = 0, gap_cnt = 0;
  logic [DB-1:0] last_keep;
  bit stall_prev = 0, gap_armed = 0;
  logic [8*DB-1:0] sv_data;
  logic [DB-1:0] sv_keep;
  logic sv_last, sv_valid;

  always @(negedge clk) begin
    if (!rstn) begin
      pos = 0; beats = 0; stall_prev = 0; gap_armed = 0;
    end else begin
      logic [8*DB-1:0] ed;
      logic [DB-1:0] ek;
      logic el;
      int L, nb;
      if (stall_prev)
        check("stall_stable", {tvalid, tlast, tkeep, tdata}, {sv_valid, sv_last, sv_keep, sv_data});
      stall_prev = tvalid && !tready;
      sv_valid = tvalid; sv_last = tlast; sv_keep = tkeep; sv_data = tdata;
      if (pos != 0) check("tvalid_hold", tvalid, 1'b1);
      if (!busy) gap_armed = 0;
      if (gap_armed && !tvalid) gap_cnt++;
      if (gap_armed && tvalid) begin
        check("ipg_gap_ok", gap_cnt >= cur_ipg, 1'b1);
        gap_armed = 0;
      end
      if (tvalid && tready) begin
        if (exp_len.size() == 0) begin
          check("unexpected_beat", tdata, '0);
          checks++; failures++;
          $display("FAIL unexpected_beat: got=beat want=no_frame");
        end else begin
          L = exp_len[0];
          nb = (L - pos < DB) ? L - pos : DB;
          ed = '0; ek = '0;
          for (int l = 0; l < nb; l++) begin
            ed[8*l +: 8] = exp_bytes[l];
            ek[l] = 1'b1;
          end
          el = (pos + DB >= L);
          check("beat", {tlast, tkeep, tdata}, {el, ek, ed});
          for (int l = 0; l < nb; l++) void'(exp_bytes.pop_front());
          pos += DB; beats++;
          if (el) begin
            void'(exp_len.pop_front());
            frames_seen++;
            last_beats = beats; last_keep = tkeep;
            $display("frame %0d accepted: %0d bytes in %0d beats", frames_seen, L, beats);
            pos = 0; beats = 0;
            gap_armed = 1; gap_cnt = 0;
          end
        end
      end
    end
  end

  initial begin
    tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic wait_busy(input logic v, input string nm);
    int n = 0;
    while (busy !== v && n < 20000) begin @(negedge clk); n++; end
    check(nm, busy, v);
  endtask

  task automatic set_cfg(input int dlen, input int mode, input int seed, input int num, input int ipg);
    @(posedge clk); #1;
    cfg_dlen = dlen; cfg_mode = mode; cfg_seed = seed; cur_ipg = ipg;
    udp_dlen = 16'(dlen); pat_mode = 2'(mode); pat_seed = 8'(seed);
    pat_gen_num = CW'(num); pat_gen_ipg = CW'(ipg);
  endtask

  task automatic start_run();
    pat_gen_en = 1'b1;
    wait_busy(1'b1, "busy_rise");
    @(posedge clk); #1;
    pat_gen_en = 1'b0;
  endtask

  task automatic finish_run(input int nexp, input int fs0);
    wait_busy(1'b0, "busy_fall");
    check("frames_left", exp_len.size(), 0);
    check("frames_seen", frames_seen - fs0, nexp);
    model_frame_cnt += nexp;
    check("frame_cnt", frame_cnt, model_frame_cnt);
  endtask

  task automatic check_shape();
    int r;
    r = frm_len % DB;
    check("beat_count", last_beats, (frm_len + DB - 1) / DB);
    check("last_tkeep", last_keep, (r == 0) ? {DB{1'b1}} : DB'((1 << r) - 1));
  endtask

  initial begin
    int fs0, n;
    rstn = 1'b0; pat_gen_en = 1'b0; pat_gen_stop = 1'b0; rand_ready = 0;
    dst_mac = 48'h001122334455; src_mac = 48'h02AABBCCDDEE;
    src_ip = 32'hC0A8010A; dst_ip = 32'hC0A80114;
    src_port = 16'h1234; dst_port = 16'h5678;
    udp_dlen = 16'd0; pat_mode = 2'd0; pat_seed = 8'd0; pat_gen_num = '0; pat_gen_ipg = '0;
    model_ip_id = 0; model_frame_cnt = 0; frames_seen = 0; cur_ipg = 0;
    repeat (4) @(negedge clk);
    check("rst_outputs", {tvalid, tlast, tkeep, tdata, busy}, '0);
    check("rst_frame_cnt", frame_cnt, 32'd0);
    @(posedge clk); #1 rstn = 1'b1;

    // 1: 18-byte payload, single frame
    set_cfg(18, 0, 0, 1, 0);
    build_frame(0);
    check("t1_len", frm_len, 60);
    check("t1_ip_csum", {frm[24], frm[25]}, 16'hF750);
    check("t1_ip_len", {frm[16], frm[17]}, 16'h002E);
    fs0 = frames_seen; start_run(); finish_run(1, fs0); check_shape();

    // 2: odd payload, constant seed
    set_cfg(19, 1, 8'hA5, 1, 0);
    build_frame(0);
    check("t2_len", frm_len, 61);
    check("t2_last_byte", frm[60], 8'hA5);
    check("t2_udp_csum", {frm[40], frm[41]}, 16'h9BC9);
    fs0 = frames_seen; start_run(); finish_run(1, fs0); check_shape();

    // 3: random backpressure, 3 frames with gap 5
    set_cfg(18, 0, 0, 3, 5);
    for (int f = 0; f < 3; f++) build_frame(f);
    check("t3_ip_id", {frm[18], frm[19]}, 16'h0004);
    rand_ready = 1;
    fs0 = frames_seen; start_run(); finish_run(3, fs0);
    rand_ready = 0;

    // 4: seed + frame index payload
    set_cfg(10, 2, 8'h10, 2, 0);
    build_frame(0);
    check("t4_f0_pay", {frm[42], frm[43]}, 16'h1011);
    build_frame(1);
    check("t4_f1_pay", {frm[42], frm[43]}, 16'h1112);
    fs0 = frames_seen; start_run(); finish_run(2, fs0);

    // 5: infinite run stopped during the fifth frame
    set_cfg(18, 0, 3, 0, 2);
    for (int f = 0; f < 5; f++) build_frame(f);
    fs0 = frames_seen; start_run();
    n = 0;
    while (!(frames_seen - fs0 == 4 && tvalid) && n < 20000) begin @(negedge clk); n++; end
    check("t5_reached_frame4", frames_seen - fs0 == 4 && tvalid, 1'b1);
    @(posedge clk); #1 pat_gen_stop = 1'b1;
    finish_run(5, fs0);
    repeat (30) @(posedge clk);
    check("t5_no_extra", frames_seen - fs0, 5);
    #1 pat_gen_stop = 1'b0;

    // 6: reset in the middle of a frame, then restart
    set_cfg(18, 0, 0, 1, 0);
    build_frame(0);
    start_run();
    n = 0;
    while (!tvalid && n < 2000) begin @(negedge clk); n++; end
    check("t6_in_gen", tvalid, 1'b1);
    repeat (3) @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    check("t6_rst_outputs", {tvalid, tlast, tkeep, tdata, busy}, '0);
    check("t6_rst_frame_cnt", frame_cnt, 32'd0);
    exp_bytes.delete(); exp_len.delete();
    model_ip_id = 0; model_frame_cnt = 0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    set_cfg(18, 0, 0, 1, 0);
    build_frame(0);
    check("t6_ip_csum", {frm[24], frm[25]}, 16'hF750);
    fs0 = frames_seen; start_run(); finish_run(1, fs0); check_shape();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end
endmodule
